// File: rtl/sar_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sar_bit_sequencer
// Description : SAR conversion sequencer. It walks a one-hot bit pointer from
//               MSB to LSB, drives the DAC trial code and captures the result.
//               Optional macro SAR_SETTLE_EN adds a settle wait before each
//               compare.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_bit_sequencer #(
    parameter int unsigned N_BITS        = 10,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp,
    output logic              busy,
    output logic [N_BITS-1:0] bitctrl,
    output logic [N_BITS-1:0] trial,
    output logic [N_BITS-1:0] result,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam logic [N_BITS-1:0] c_msb = {1'b1, {(N_BITS-1){1'b0}}};

    state_t            r_state, w_state_nxt;
    logic              r_busy, w_busy_nxt;
    logic [N_BITS-1:0] r_bitctrl, w_bitctrl_nxt;
    logic [N_BITS-1:0] r_trial, w_trial_nxt;
    logic [N_BITS-1:0] r_result, w_result_nxt;
    logic              r_done, w_done_nxt;
    logic              w_step;
    logic [N_BITS-1:0] w_decided;

`ifdef SAR_SETTLE_EN
    localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);
    logic [3:0] r_settle;

    // Compare only once the DAC has had SETTLE_CYCLES edges to settle.
    assign w_step = (r_settle == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= 4'd0;
        end else if (r_state == IDLE && start) begin
            r_settle <= c_settle;
        end else if (r_state == CONVERT) begin
            r_settle <= w_step ? c_settle : r_settle - 4'd1;
        end
    end
`else
    logic w_unused_settle;
    assign w_unused_settle = ^SETTLE_CYCLES;
    assign w_step          = 1'b1;
`endif

    // Trial code with the bit under test replaced by the comparator decision.
    assign w_decided = (r_trial & ~r_bitctrl) | (cmp ? r_bitctrl : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_bitctrl <= '0;
            r_trial   <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_bitctrl <= w_bitctrl_nxt;
            r_trial   <= w_trial_nxt;
            r_result  <= w_result_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_bitctrl_nxt = r_bitctrl;
        w_trial_nxt   = r_trial;
        w_result_nxt  = r_result;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = CONVERT;
                    w_busy_nxt    = 1'b1;
                    w_bitctrl_nxt = c_msb;
                    w_trial_nxt   = c_msb;
                end
            end
            CONVERT: begin
                if (w_step) begin
                    if (r_bitctrl[0]) begin
                        w_state_nxt   = FINISH;
                        w_busy_nxt    = 1'b0;
                        w_bitctrl_nxt = '0;
                        w_trial_nxt   = w_decided;
                        w_result_nxt  = w_decided;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_bitctrl_nxt = r_bitctrl >> 1;
                        w_trial_nxt   = w_decided | (r_bitctrl >> 1);
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign bitctrl = r_bitctrl;
    assign trial   = r_trial;
    assign result  = r_result;
    assign done    = r_done;

endmodule
`default_nettype wire
